// File: rtl/rc4_keysearch_dispatcher.sv
// Interleaves the RC4 key space over NUM_CORES cores and stops all of them on the first hit.
// start->core_start 2 cycles, done->relaunch 1 cycle; cores are paced only by their own done pulses.
module rc4_keysearch_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic                           start,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic [NUM_CORES-1:0]           core_abort,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found,
  output logic                           busy,
  output logic                           found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic                           exhausted
);

  localparam logic [KEY_WIDTH:0] KMAX_X = {1'b0, KEY_MAX};
  localparam logic [KEY_WIDTH:0] STEP_X = (KEY_WIDTH+1)'(NUM_CORES);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_FOUND, S_EXHAUSTED} state_t;
  state_t state, state_nxt;

  logic [KEY_WIDTH-1:0] key_q   [NUM_CORES];
  logic [KEY_WIDTH-1:0] key_nxt [NUM_CORES];
  logic [NUM_CORES-1:0] active, retired, retired_nxt;
  logic [NUM_CORES-1:0] svc, hit, win, relaunch;
  logic [KEY_WIDTH:0]   sum;
  logic [KEY_WIDTH-1:0] win_key;
  logic                 all_retired;

  // Per-core servicing; the sum is one bit wider so the step past KEY_MAX cannot wrap.
  always_comb begin
    svc         = (state == S_RUN) ? (core_done & active) : '0;
    hit         = svc & core_found;
    win         = '0;
    win_key     = '0;
    key_nxt     = key_q;
    retired_nxt = retired;
    relaunch    = '0;
    sum         = '0;
    for (int c = NUM_CORES-1; c >= 0; c--) begin
      if (hit[c]) begin
        win      = '0;
        win[c]   = 1'b1;
        win_key  = key_q[c];
      end
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (svc[c] && !core_found[c]) begin
        sum = {1'b0, key_q[c]} + STEP_X;
        if (sum <= KMAX_X) begin
          key_nxt[c]  = sum[KEY_WIDTH-1:0];
          relaunch[c] = 1'b1;
        end else begin
          retired_nxt[c] = 1'b1;
        end
      end
    end
    all_retired = &retired_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: if (start) state_nxt = S_LAUNCH;
      S_LAUNCH:                     state_nxt = S_RUN;
      S_RUN: begin
        if (|hit)             state_nxt = S_FOUND;
        else if (all_retired) state_nxt = S_EXHAUSTED;
      end
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CORES; c++) key_q[c] <= '0;
      active     <= '0;
      retired    <= '0;
      core_start <= '0;
      core_abort <= '0;
      found      <= 1'b0;
      found_key  <= '0;
      exhausted  <= 1'b0;
    end else begin
      core_start <= '0;
      core_abort <= '0;
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            found_key <= '0;
            active    <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
              key_q[c]   <= KEY_WIDTH'(c);
              retired[c] <= ((KEY_WIDTH+1)'(c) > KMAX_X);
            end
          end
        end
        S_LAUNCH: begin
          core_start <= ~retired;
          active     <= ~retired;
        end
        S_RUN: begin
          if (|hit) begin
            found      <= 1'b1;
            found_key  <= win_key;
            core_abort <= active & ~win;
            active     <= '0;
          end else begin
            key_q      <= key_nxt;
            retired    <= retired_nxt;
            core_start <= relaunch;
            active     <= (active & ~svc) | relaunch;
            exhausted  <= all_retired;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
  end

  assign busy = (state == S_LAUNCH) || (state == S_RUN);

endmodule

// File: tb/tb_rc4_keysearch_dispatcher.sv
// Three dispatcher configurations driven by randomly-timed core models; a monitor
// checks every launch key and search outcome against a scoreboard filled by the stimulus.
module tb_rc4_keysearch_dispatcher;
  localparam int KW = 8;
  localparam int NI = 3;

  typedef struct packed {
    logic          fnd;
    logic          exh;
    logic [KW-1:0] key;
    logic [3:0]    abort;
  } out_t;

  logic          clk;
  logic          reset_n;
  logic [NI-1:0] start;
  logic [NI-1:0] busy, found, exhausted;
  logic [3:0]    cdone  [NI];
  logic [3:0]    cfound [NI];
  logic [3:0]    cs_a, cs_b, ca_a, ca_b;
  logic [0:0]    cs_c, ca_c;
  logic [31:0]   ck_a, ck_b;
  logic [KW-1:0] ck_c, fk_a, fk_b, fk_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   exp_key  [NI][4][$];
  out_t out_q    [NI][$];
  int   launch_q [NI][$];
  bit          pend [NI][4];
  bit          fin  [NI][4];
  int          cntd [NI][4];
  int          pkey [NI][4];
  int          mkey [NI][4];
  bit          over [NI];
  bit          lock [NI];
  bit [15:0]   secret [NI];

  rc4_keysearch_dispatcher #(.NUM_CORES(4), .KEY_WIDTH(KW), .KEY_MAX(8'd15)) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[0]), .core_start(cs_a), .core_key(ck_a),
    .core_abort(ca_a), .core_done(cdone[0]), .core_found(cfound[0]), .busy(busy[0]),
    .found(found[0]), .found_key(fk_a), .exhausted(exhausted[0]));
  rc4_keysearch_dispatcher #(.NUM_CORES(4), .KEY_WIDTH(KW), .KEY_MAX(8'd2)) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[1]), .core_start(cs_b), .core_key(ck_b),
    .core_abort(ca_b), .core_done(cdone[1]), .core_found(cfound[1]), .busy(busy[1]),
    .found(found[1]), .found_key(fk_b), .exhausted(exhausted[1]));
  rc4_keysearch_dispatcher #(.NUM_CORES(1), .KEY_WIDTH(KW), .KEY_MAX(8'd3)) dut_c (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[2]), .core_start(cs_c), .core_key(ck_c),
    .core_abort(ca_c), .core_done(cdone[2][0]), .core_found(cfound[2][0]), .busy(busy[2]),
    .found(found[2]), .found_key(fk_c), .exhausted(exhausted[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nc(int i); return (i == 2) ? 1 : 4; endfunction
  function automatic int km(int i); return (i == 0) ? 15 : (i == 1) ? 2 : 3; endfunction

  function automatic logic [3:0] cstart_of(int i);
    case (i) 0: return cs_a; 1: return cs_b; default: return {3'b0, cs_c}; endcase
  endfunction
  function automatic logic [3:0] cabort_of(int i);
    case (i) 0: return ca_a; 1: return ca_b; default: return {3'b0, ca_c}; endcase
  endfunction
  function automatic logic [KW-1:0] fkey_of(int i);
    case (i) 0: return fk_a; 1: return fk_b; default: return fk_c; endcase
  endfunction
  function automatic logic [31:0] ckall_of(int i);
    case (i) 0: return ck_a; 1: return ck_b; default: return {24'b0, ck_c}; endcase
  endfunction
  function automatic logic [KW-1:0] ckey_of(int i, int c);
    logic [31:0] v;
    v = ckall_of(i);
    return v[c*KW +: KW];
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_busy"},      i, 32'(busy[i]), 0);
      chk({nm, "_found"},     i, 32'(found[i]), 0);
      chk({nm, "_exhausted"}, i, 32'(exhausted[i]), 0);
      chk({nm, "_found_key"}, i, 32'(fkey_of(i)), 0);
      chk({nm, "_core_start"},i, 32'(cstart_of(i)), 0);
      chk({nm, "_core_abort"},i, 32'(cabort_of(i)), 0);
      chk({nm, "_core_key"},  i, ckall_of(i), 0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      over[i] = 1'b1;
      out_q[i].delete();
      launch_q[i].delete();
      for (int c = 0; c < 4; c++) begin
        pend[i][c] = 1'b0;
        exp_key[i][c].delete();
      end
      cdone[i]  = '0;
      cfound[i] = '0;
    end
    start = '0;
  endtask

  // One cycle of core behaviour: inputs change 1 time unit after the falling edge.
  task automatic step();
    logic [3:0] cs, dn, ht, infl;
    int dkey [4];
    int w;
    bit all_fin;
    @(negedge clk);
    #1;
    start = '0;
    for (int i = 0; i < NI; i++) begin
      cs = cstart_of(i);
      dn = '0; ht = '0; infl = '0;
      for (int c = 0; c < 4; c++) dkey[c] = 0;
      if (!over[i]) begin
        for (int c = 0; c < nc(i); c++) infl[c] = pend[i][c] | cs[c];
        for (int c = 0; c < nc(i); c++) begin
          if (pend[i][c]) begin
            if (cntd[i][c] == 1) begin
              pend[i][c] = 1'b0;
              dn[c]      = 1'b1;
              dkey[c]    = pkey[i][c];
              if (pkey[i][c] < 16 && secret[i][pkey[i][c]]) ht[c] = 1'b1;
              else if (pkey[i][c] + nc(i) > km(i)) fin[i][c] = 1'b1;
            end else begin
              cntd[i][c]--;
            end
          end
        end
        for (int c = 0; c < nc(i); c++) begin
          if (cs[c]) begin
            pend[i][c] = 1'b1;
            pkey[i][c] = mkey[i][c];
            mkey[i][c] += nc(i);
            cntd[i][c] = lock[i] ? 1 : $urandom_range(1, 3);
          end
        end
        all_fin = 1'b1;
        for (int c = 0; c < 4; c++) all_fin &= fin[i][c];
        if (ht != 0) begin
          w = 0;
          for (int c = 3; c >= 0; c--) if (ht[c]) w = c;
          out_q[i].push_back('{fnd: 1'b1, exh: 1'b0, key: KW'(dkey[w]),
                               abort: infl & ~(4'b1 << w)});
          over[i] = 1'b1;
          for (int c = 0; c < 4; c++) begin
            pend[i][c] = 1'b0;
            exp_key[i][c].delete();
          end
        end else if (all_fin) begin
          out_q[i].push_back('{fnd: 1'b0, exh: 1'b1, key: '0, abort: '0});
          over[i] = 1'b1;
        end
      end
      cdone[i]  = dn;
      cfound[i] = (4'($urandom) & ~dn) | ht;
      if (busy[i] && $urandom_range(0, 9) == 0) start[i] = 1'b1;
    end
  endtask

  task automatic launch_all();
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      over[i] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        pend[i][c] = 1'b0;
        fin[i][c]  = (c >= nc(i)) || (c > km(i));
        mkey[i][c] = c;
        exp_key[i][c].delete();
        if (c < nc(i))
          for (int k = c; k <= km(i); k += nc(i)) exp_key[i][c].push_back(k);
      end
      launch_q[i].push_back(cyc + 2);
      cdone[i]  = '0;
      cfound[i] = '0;
    end
    start = '1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: consumes the scoreboard whenever a DUT presents a launch or an outcome.
  initial begin
    bit         prev_end [NI];
    logic [3:0] cs;
    int         e;
    out_t       o;
    bit         endnow;
    for (int i = 0; i < NI; i++) prev_end[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < NI; i++) prev_end[i] = 1'b0;
        continue;
      end
      for (int i = 0; i < NI; i++) begin
        cs = cstart_of(i);
        for (int c = 0; c < nc(i); c++) begin
          if (cs[c]) begin
            if (exp_key[i][c].size() == 0) begin
              chk("unexpected_core_start", i, 32'(c), 32'hFFFF);
            end else begin
              e = exp_key[i][c].pop_front();
              chk("core_key", i, 32'(ckey_of(i, c)), 32'(e));
              if (c == 0 && e == 0) begin
                if (launch_q[i].size() == 0) chk("unexpected_launch", i, 32'(cyc), 32'hFFFF);
                else chk("launch_latency", i, 32'(cyc), 32'(launch_q[i].pop_front()));
              end
            end
          end
        end
        endnow = found[i] | exhausted[i];
        if (endnow && !prev_end[i]) begin
          if (out_q[i].size() == 0) begin
            chk("unexpected_outcome", i, {found[i], exhausted[i]}, 32'hFFFF);
          end else begin
            o = out_q[i].pop_front();
            chk("found",      i, 32'(found[i]), 32'(o.fnd));
            chk("exhausted",  i, 32'(exhausted[i]), 32'(o.exh));
            chk("found_key",  i, 32'(fkey_of(i)), 32'(o.key));
            chk("core_abort", i, 32'(cabort_of(i)), 32'(o.abort));
            chk("busy_at_end",i, 32'(busy[i]), 0);
          end
        end else if (cabort_of(i) != 0) begin
          chk("spurious_abort", i, 32'(cabort_of(i)), 0);
        end
        if (endnow) chk("found_and_exhausted", i, 32'(found[i] & exhausted[i]), 0);
        prev_end[i] = endnow;
      end
    end
  end

  initial begin
    int  n;
    bit  idle;
    int  mode;
    reset_n = 1'b0;
    clear_model();
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NI; i++) begin
        lock[i]   = ($urandom_range(0, 1) == 1);
        secret[i] = '0;
        mode      = $urandom_range(0, 2);
        if (mode == 1) secret[i][$urandom_range(0, km(i))] = 1'b1;
        if (mode == 2)
          for (int k = 0; k <= km(i); k++) if ($urandom_range(0, 4) == 0) secret[i][k] = 1'b1;
      end
      if (r == 0) begin
        lock   = '{1'b1, 1'b1, 1'b0};
        secret = '{16'h0040, 16'h0000, 16'h0008};
      end else if (r == 1) begin
        lock   = '{1'b1, 1'b1, 1'b1};
        secret = '{16'h00A0, 16'h0000, 16'h0000};
      end else if (r == 2) begin
        lock   = '{1'b1, 1'b0, 1'b1};
        secret = '{16'h0000, 16'h0000, 16'h0004};
      end
      launch_all();
      if (r == 5) begin
        repeat (6) step();
        mid_reset();
        continue;
      end
      n = 0;
      idle = 1'b0;
      while (!idle && n < 400) begin
        step();
        n++;
        idle = (busy == '0);
        for (int i = 0; i < NI; i++) idle &= over[i] && (out_q[i].size() == 0);
      end
      chk("search_completes", r, 32'(idle), 1);
      step();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
